boardman_host_sm: RTL
=====================

BOARDMAN_HOST_SM -- requirements
Module: boardman_host_sm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning response wait limit in clk cycles (1 ms at 100 MHz).
REQ-002 SHALL have ports clk (input, 1, the only clock) and rst_n (input, 1): reset is asynchronous and active-low.
REQ-003 SHALL have local bus ports:
- s_adr_i (input, 20): word address.
- s_dat_i (input, 32): write data.
- s_en_i (input, 1): request.
- s_wr_i (input, 1): 1 = write.
- s_dat_o (output, 32): read data.
- s_ack_o (output, 1): completion pulse.
- s_err_o (output, 1): error, valid with ack.
REQ-004 SHALL have the pre-COBS TX stream m_axis_tx_tdata (output, 8), m_axis_tx_tvalid (output, 1), m_axis_tx_tready (input, 1) and m_axis_tx_tlast (output, 1).
REQ-005 SHALL have the post-COBS RX stream s_axis_rx_tdata (input, 8), s_axis_rx_tvalid (input, 1), s_axis_rx_tready (output, 1), s_axis_rx_tlast (input, 1) and s_axis_rx_tuser (input, 1, frame error flag).

Function
REQ-006 SHALL act as the initiator for the board-manager serial protocol: one local bus transaction produces one request frame and consumes one response frame.
REQ-007 SHALL form the header as the 24-bit byte address H = {wr, 1'b0, adr[19:0], 2'b00}, sent MSB byte first.
REQ-008 SHALL encode requests as:
- Write: H[23:16], H[15:8], H[7:0], then dat[31:24], [23:16], [15:8], [7:0]; 7 bytes, tlast on byte 7.
- Read: the 3 header bytes, then length byte 8'h03 (byte count minus 1); 4 bytes, tlast on byte 4.
REQ-009 SHALL require responses of:
- Write: echoed 3-byte header plus 1 count byte of any value (4 bytes).
- Read: echoed 3-byte header plus 4 data bytes, MSB first (7 bytes).
REQ-010 SHALL implement the states IDLE, TX, RX, FLUSH and DONE.
REQ-011 SHALL, in IDLE with s_en_i=1, latch adr/dat/wr and go to TX on the next cycle; inputs are ignored outside IDLE.
REQ-012 SHALL, in TX, hold tvalid high and hold tdata stable until tready; the byte index advances only on a tvalid&tready beat; the tlast beat transfers go to RX.
REQ-013 SHALL, in RX, hold tready=1, accept one byte per beat and compare each header byte to H.
REQ-014 SHALL treat any of these as a protocol error:
- header mismatch;
- tuser=1 on any beat;
- tlast before the expected final byte;
- no tlast on the expected final byte.
REQ-015 SHALL go to FLUSH on a protocol error whose beat lacked tlast, and straight to DONE with error if that beat had tlast.
REQ-016 SHALL, in FLUSH, hold tready=1 and discard beats until tlast, then go to DONE with error.
REQ-017 SHALL drive tready=1 in IDLE and discard stray bytes there, so late responses are dropped.
REQ-018 SHALL run a timeout counter that clears on entry to RX and increments every cycle in RX/FLUSH.
REQ-019 SHALL, on reaching TIMEOUT_CYCLES-1 with no completion, go to DONE with error.
REQ-020 SHALL, in DONE, pulse s_ack_o for exactly 1 cycle and return to IDLE.
REQ-021 SHALL, with ack on success, drive s_err_o=0 and s_dat_o = read data (reads) or 32'h0 (writes).
REQ-022 SHALL, with ack on error, drive s_err_o=1 and s_dat_o=32'hFFFFFFFF.
REQ-023 SHALL keep s_dat_o stable until the next ack.
REQ-024 SHALL give minimum latency, with tready always high, of s_en_i to ack = 1 + N_tx + N_rx + 1 cycles.
REQ-025 SHALL let the master deassert s_en_i in the cycle after ack; an s_en_i still high in the cycle after ack starts a new transaction.
REQ-026 SHALL give a timeout priority below a same-cycle final-byte completion: completion wins.

Reset
REQ-027 SHALL, on rst_n low, asynchronously drive state=IDLE, s_ack_o=0, s_err_o=0, s_dat_o=32'h0, m_axis_tx_tvalid=0, m_axis_tx_tlast=0, s_axis_rx_tready=0 and clear the counters.
REQ-028 SHALL, on reset mid-transaction, abandon the transaction with no ack; after release it is in IDLE with s_axis_rx_tready=1 one cycle later.

Structure
REQ-029 SHALL place in shared package boardman_pkg: the state encoding, the WR bit position (23), the request/response lengths (7/4, 4/7) and the read length byte 8'h03.
REQ-030 SHALL use one sub-module, boardman_host_timer (clear, enable, terminal count at TIMEOUT_CYCLES-1), and keep the serialiser inline.

Verification
REQ-031 SHALL cover a write of adr=20'h00010, dat=32'hDEADBEEF: TX 80 00 40 DE AD BE EF with tlast on EF; reply 80 00 40 04 -> ack with err=0.
REQ-032 SHALL cover a read of adr=20'h12345: TX 04 8D 14 03; reply 04 8D 14 CA FE BA BE -> s_dat_o=32'hCAFEBABE, err=0.
REQ-033 SHALL cover a read with reply header 04 8D 15 then 4 bytes and tlast -> all bytes consumed, ack with err=1 and s_dat_o=32'hFFFFFFFF.
REQ-034 SHALL cover a read with no reply and TIMEOUT_CYCLES=50: ack with err=1 exactly 50 cycles after RX entry; a late 7-byte reply is then discarded in IDLE.
REQ-035 SHALL cover TX tready toggled randomly at 50% duty: the byte order is unchanged and tdata is held while stalled.
REQ-036 SHALL cover rst_n asserted during RX byte 3: no ack, all outputs at reset values, and the next transaction completes normally.

Source files
------------

// File: rtl/boardman_pkg.sv
// Shared definitions for the board-manager serial protocol host:
// state encoding, frame lengths and header construction.
package boardman_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_RX,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam int WR_BIT = 23;

    localparam logic [2:0] TX_LEN_WR = 3'd7;
    localparam logic [2:0] TX_LEN_RD = 3'd4;
    localparam logic [2:0] RX_LEN_WR = 3'd4;
    localparam logic [2:0] RX_LEN_RD = 3'd7;

    localparam logic [7:0] RD_LEN_BYTE = 8'h03;

    // Header is the byte address of the word with the write flag on top.
    function automatic logic [23:0] make_header(input logic wr, input logic [19:0] adr);
        logic [23:0] h;
        h = {2'b00, adr, 2'b00};
        h[WR_BIT] = wr;
        return h;
    endfunction

endpackage

// File: rtl/boardman_host_timer.sv
// Response wait timer: counts enabled cycles since the last clear and flags
// the terminal count at TIMEOUT_CYCLES-1.
module boardman_host_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign done = (count == TERMINAL);

    // Saturate at terminal so a stalled owner never sees the flag drop again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/boardman_host_sm.sv
// Board-manager protocol initiator: turns one local bus access into a request
// frame on the TX stream and validates the matching response on the RX stream.
module boardman_host_sm
    import boardman_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    input  logic        s_en_i,
    input  logic        s_wr_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic        s_err_o,
    output logic [7:0]  m_axis_tx_tdata,
    output logic        m_axis_tx_tvalid,
    input  logic        m_axis_tx_tready,
    output logic        m_axis_tx_tlast,
    input  logic [7:0]  s_axis_rx_tdata,
    input  logic        s_axis_rx_tvalid,
    output logic        s_axis_rx_tready,
    input  logic        s_axis_rx_tlast,
    input  logic        s_axis_rx_tuser
);

    state_t      state, state_next;
    logic [19:0] adr_q;
    logic [31:0] dat_q;
    logic        wr_q;
    logic [2:0]  idx;
    logic [23:0] rd_shift;
    logic        rx_live;
    logic [23:0] hdr;
    logic [7:0]  hdr_byte;
    logic [2:0]  tx_last_idx, rx_last_idx;
    logic        tx_beat, rx_beat, hdr_bad, rx_final, rx_err;
    logic        timer_clr, timer_en, timer_done;
    logic        latch, idx_clr, idx_inc, finish, finish_err;
    logic [31:0] finish_data;

    assign hdr         = make_header(wr_q, adr_q);
    assign tx_last_idx = wr_q ? TX_LEN_WR - 3'd1 : TX_LEN_RD - 3'd1;
    assign rx_last_idx = wr_q ? RX_LEN_WR - 3'd1 : RX_LEN_RD - 3'd1;

    assign m_axis_tx_tvalid = (state == ST_TX);
    assign m_axis_tx_tlast  = (state == ST_TX) && (idx == tx_last_idx);
    // rx_live keeps tready low while in reset and for the first cycle after it.
    assign s_axis_rx_tready = rx_live &&
                              ((state == ST_IDLE) || (state == ST_RX) || (state == ST_FLUSH));
    assign s_ack_o          = (state == ST_DONE);

    assign tx_beat = m_axis_tx_tvalid && m_axis_tx_tready;
    assign rx_beat = s_axis_rx_tvalid && s_axis_rx_tready;

    always_comb begin
        m_axis_tx_tdata = dat_q[7:0];
        hdr_byte        = hdr[7:0];
        case (idx)
            3'd0:    m_axis_tx_tdata = hdr[23:16];
            3'd1:    m_axis_tx_tdata = hdr[15:8];
            3'd2:    m_axis_tx_tdata = hdr[7:0];
            3'd3:    m_axis_tx_tdata = wr_q ? dat_q[31:24] : RD_LEN_BYTE;
            3'd4:    m_axis_tx_tdata = dat_q[23:16];
            3'd5:    m_axis_tx_tdata = dat_q[15:8];
            default: m_axis_tx_tdata = dat_q[7:0];
        endcase
        case (idx)
            3'd0:    hdr_byte = hdr[23:16];
            3'd1:    hdr_byte = hdr[15:8];
            default: hdr_byte = hdr[7:0];
        endcase
    end

    assign hdr_bad  = (idx < 3'd3) && (s_axis_rx_tdata != hdr_byte);
    assign rx_final = (idx == rx_last_idx);
    assign rx_err   = hdr_bad || s_axis_rx_tuser || (s_axis_rx_tlast != rx_final);

    assign finish_data = finish_err ? 32'hFFFF_FFFF :
                         (wr_q ? 32'h0 : {rd_shift, s_axis_rx_tdata});

    boardman_host_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clr),
        .enable(timer_en),
        .done  (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A completing final beat takes priority over a same-cycle timeout.
    always_comb begin
        state_next = state;
        latch      = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_en_i) begin
                    latch      = 1'b1;
                    idx_clr    = 1'b1;
                    state_next = ST_TX;
                end
            end
            ST_TX: begin
                if (tx_beat) begin
                    if (m_axis_tx_tlast) begin
                        idx_clr    = 1'b1;
                        timer_clr  = 1'b1;
                        state_next = ST_RX;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_RX: begin
                timer_en = 1'b1;
                if (rx_beat && (rx_err ? s_axis_rx_tlast : rx_final)) begin
                    finish     = 1'b1;
                    finish_err = rx_err;
                end else if (timer_done) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (rx_beat && rx_err) begin
                    state_next = ST_FLUSH;
                end else if (rx_beat) begin
                    idx_inc = 1'b1;
                end
            end
            ST_FLUSH: begin
                timer_en = 1'b1;
                if ((rx_beat && s_axis_rx_tlast) || timer_done) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (finish) begin
            state_next = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_live  <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            wr_q     <= 1'b0;
            idx      <= '0;
            rd_shift <= '0;
            s_err_o  <= 1'b0;
            s_dat_o  <= '0;
        end else begin
            rx_live <= 1'b1;
            if (latch) begin
                adr_q <= s_adr_i;
                dat_q <= s_dat_i;
                wr_q  <= s_wr_i;
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 3'd1;
            end
            if ((state == ST_RX) && rx_beat) begin
                rd_shift <= {rd_shift[15:0], s_axis_rx_tdata};
            end
            if (finish) begin
                s_err_o <= finish_err;
                s_dat_o <= finish_data;
            end
        end
    end

endmodule
